// File: rtl/m_dm_stall_pkg.sv
// Shared type codes, FSM states and the latched-request record for the stalling data memory.
package m_dm_stall_pkg;

  typedef enum logic [2:0] {
    DM_b  = 3'd0,
    DM_h  = 3'd1,
    DM_w  = 3'd2,
    DM_bu = 3'd4,
    DM_hu = 3'd5
  } dm_type_e;

  typedef enum logic [2:0] {
    S_SCRUB  = 3'd0,
    S_IDLE   = 3'd1,
    S_WAIT   = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
  } dm_req_t;

  function automatic logic dm_is_unsigned(input logic [2:0] ty);
    return (ty == DM_hu) || (ty == DM_bu);
  endfunction

endpackage

// File: rtl/m_dm_stall_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface m_dm_stall_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wd;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wd, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wd, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/m_dm_stall_lane.sv
// Byte-lane logic: extracts/extends load data, merges store data into the old word,
// and flags misalignment or an undefined access type.
module m_dm_lane
  import m_dm_stall_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wd,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word,
  output logic        o_lane_err
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_addr_lo[1] ? i_old_word[31:16] : i_old_word[15:0];
  assign w_byte = i_old_word[{i_addr_lo, 3'b000} +: 8];

  always_comb begin
    o_load_data   = '0;
    o_merged_word = i_old_word;
    o_lane_err    = 1'b0;
    case (i_type)
      DM_w: begin
        o_lane_err    = |i_addr_lo;
        o_load_data   = i_old_word;
        o_merged_word = i_wd;
      end
      DM_h, DM_hu: begin
        o_lane_err  = i_addr_lo[0];
        o_load_data = (i_type == DM_h) ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
        if (i_addr_lo[1]) o_merged_word[31:16] = i_wd[15:0];
        else              o_merged_word[15:0]  = i_wd[15:0];
      end
      DM_b, DM_bu: begin
        o_load_data = (i_type == DM_b) ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
        o_merged_word[{i_addr_lo, 3'b000} +: 8] = i_wd[7:0];
      end
      default: o_lane_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/m_dm_stall.sv
// Multi-cycle data memory with programmable wait states and post-reset scrub.
// Define DM_TRACE_EN to print every successful store (word-aligned address, merged word).
module m_dm_stall
  import m_dm_stall_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  m_dm_stall_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  dm_state_e     r_state;
  logic [AW-1:0] r_scrub_ptr;
  logic [3:0]    r_cnt;
  dm_req_t       r_req;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;
  logic          r_busy;
`ifdef DM_TRACE_EN
  logic [31:0]   r_pc;
`endif

  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [31:0]   w_load;
  logic [31:0]   w_merged;
  logic          w_lane_err;
  logic          w_range_err;
  logic          w_err;
  logic          w_wr_en;

  assign w_idx = r_req.addr[AW+1:2];
  assign w_old = r_mem[w_idx];

  m_dm_lane u_lane (
    .i_type        (r_req.ty),
    .i_addr_lo     (r_req.addr[1:0]),
    .i_old_word    (w_old),
    .i_wd          (r_req.wd),
    .o_load_data   (w_load),
    .o_merged_word (w_merged),
    .o_lane_err    (w_lane_err)
  );

  // DEPTH is a power of two, so "word index >= DEPTH" is any set bit above the index field.
  assign w_range_err = |r_req.addr[31:AW+2];
  assign w_err       = w_lane_err | w_range_err | (r_req.we & dm_is_unsigned(r_req.ty));
  assign w_wr_en     = (r_state == S_ACCESS) && r_req.we && !w_err;

  always_ff @(posedge clk) begin
    if (r_state == S_SCRUB) r_mem[r_scrub_ptr] <= '0;
    else if (w_wr_en)       r_mem[w_idx]       <= w_merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_SCRUB;
      r_scrub_ptr <= '0;
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b1;
`ifdef DM_TRACE_EN
      r_pc        <= '0;
`endif
    end else begin
      case (r_state)
        S_SCRUB: begin
          r_scrub_ptr <= r_scrub_ptr + 1'b1;
          if (r_scrub_ptr == AW'(DEPTH - 1)) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_req.we    <= bus.req_we;
            r_req.ty    <= bus.req_type;
            r_req.addr  <= bus.req_addr;
            r_req.wd    <= bus.req_wd;
`ifdef DM_TRACE_EN
            r_pc        <= bus.req_pc;
`endif
            r_cnt       <= 4'(LATENCY);
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= (LATENCY == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_err;
          r_rsp_rdata <= (w_err || r_req.we) ? '0 : w_load;
          r_state     <= S_RESP;
`ifdef DM_TRACE_EN
          if (w_wr_en)
            $display("%d@%h: *%h <= %h", $time, r_pc, {r_req.addr[31:2], 2'b00}, w_merged);
`endif
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_SCRUB;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_m_dm_stall.sv
// Scoreboard bench: two instances (LATENCY 2 and 0) against a byte-array reference memory.
module tb_m_dm_stall;
  import m_dm_stall_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 0;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  m_dm_stall_if bus_a ();
  m_dm_stall_if bus_b ();

  m_dm_stall #(.DEPTH(DEPTH), .LATENCY(LAT_A)) u_dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  m_dm_stall #(.DEPTH(DEPTH), .LATENCY(LAT_B)) u_dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  logic [7:0] mb [2][4*DEPTH];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction

  function automatic logic [3:0] flags(input int w);
    if (w == 0) return {bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_a.busy};
    return {bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err, bus_b.busy};
  endfunction

  function automatic logic [31:0] rdata_of(input int w);
    return (w == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
  endfunction

  task automatic drive(input int w, input logic v, input logic we, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] pc;
    pc = $urandom;
    if (w == 0) begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_type = ty;
      bus_a.req_addr = a; bus_a.req_wd = wd; bus_a.req_pc = pc;
    end else begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_type = ty;
      bus_b.req_addr = a; bus_b.req_wd = wd; bus_b.req_pc = pc;
    end
  endtask

  // Reference: memory as bytes; size/sign from the type, legality from alignment and range.
  task automatic model(input int w, input logic we, input logic [2:0] ty, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned size;
    bit sgn;
    logic [31:0] v;
    size = 0; sgn = 0; v = '0; rd = '0;
    case (ty)
      DM_w:  size = 4;
      DM_h:  begin size = 2; sgn = 1; end
      DM_hu: size = 2;
      DM_b:  begin size = 1; sgn = 1; end
      DM_bu: size = 1;
      default: size = 0;
    endcase
    if (size == 0) err = 1'b1;
    else err = (a % size != 0) || (a / 4 >= DEPTH) || (we && !sgn && size < 4);
    if (!err) begin
      if (we) begin
        for (int k = 0; k < int'(size); k++) mb[w][a + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < int'(size); k++) v[8*k +: 8] = mb[w][a + k];
        if (sgn && v[8*size-1])
          for (int k = int'(size); k < 4; k++) v[8*k +: 8] = 8'hFF;
        rd = v;
      end
    end
  endtask

  task automatic issue(input int w, input logic we, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int unsigned n;
    n = 0;
    drive(w, 1'b1, we, ty, a, wd);
    while (!rdy(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(w)) begin
      chk("accept_timeout", 1, 0);
      drive(w, 1'b0, 1'b0, DM_w, '0, '0);
      return;
    end
    model(w, we, ty, a, wd, e.rdata, e.err);
    e.cyc = cyc + ((w == 0) ? LAT_A : LAT_B) + 2;
    if (w == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, DM_w, '0, '0);
    chk("ready_low_after_accept", rdy(w), 0);
    chk("busy_after_accept", flags(w) & 4'b0001, 1);
  endtask

  task automatic do_reset(input int w, input logic [31:0] a0);
    int unsigned n;
    n = 0;
    if (w == 0) begin rst_a = 1'b1; q_a.delete(); end
    else        begin rst_b = 1'b1; q_b.delete(); end
    for (int k = 0; k < int'(4*DEPTH); k++) mb[w][k] = 8'h00;
    drive(w, 1'b0, 1'b0, DM_w, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_flags", flags(w), 4'b0001);
    chk("reset_rdata", rdata_of(w), 0);
    drive(w, 1'b1, 1'b0, DM_w, a0, '0);
    if (w == 0) rst_a = 1'b0;
    else        rst_b = 1'b0;
    while (!rdy(w) && n < 4*DEPTH) begin
      n++;
      @(negedge clk);
    end
    chk("scrub_cycles", n, DEPTH);
    issue(w, 1'b0, DM_w, a0, '0);
  endtask

  task automatic rand_ops(input int w, input int unsigned count);
    for (int unsigned i = 0; i < count; i++)
      issue(w, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 4*DEPTH + 7)), $urandom);
  endtask

  always @(negedge clk) begin
    if (!rst_a && bus_a.rsp_valid) begin
      if (q_a.size() == 0) chk("a_unexpected_rsp", 1, 0);
      else begin
        ea = q_a.pop_front();
        chk("a_rdata", bus_a.rsp_rdata, ea.rdata);
        chk("a_err", bus_a.rsp_err, ea.err);
        chk("a_latency", cyc, ea.cyc);
        chk("a_ready_in_resp", bus_a.req_ready, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && bus_b.rsp_valid) begin
      if (q_b.size() == 0) chk("b_unexpected_rsp", 1, 0);
      else begin
        eb = q_b.pop_front();
        chk("b_rdata", bus_b.rsp_rdata, eb.rdata);
        chk("b_err", bus_b.rsp_err, eb.err);
        chk("b_latency", cyc, eb.cyc);
        chk("b_ready_in_resp", bus_b.req_ready, 0);
      end
    end
  end

  initial begin
    int unsigned n;
    drive(0, 1'b0, 1'b0, DM_w, '0, '0);
    drive(1, 1'b0, 1'b0, DM_w, '0, '0);
    repeat (3) @(negedge clk);

    do_reset(0, 32'h0000_0024);
    issue(0, 1'b1, DM_w,  32'h10, 32'h1234_5678);
    issue(0, 1'b0, DM_w,  32'h10, '0);
    issue(0, 1'b1, DM_b,  32'h11, 32'h0000_00AB);
    issue(0, 1'b0, DM_b,  32'h11, '0);
    issue(0, 1'b0, DM_bu, 32'h11, '0);
    issue(0, 1'b0, DM_w,  32'h10, '0);
    issue(0, 1'b0, DM_w,  32'h12, '0);
    issue(0, 1'b0, DM_h,  32'h13, '0);
    issue(0, 1'b1, DM_bu, 32'h00, 32'hFFFF_FFFF);
    issue(0, 1'b1, DM_hu, 32'h10, 32'hFFFF_FFFF);
    issue(0, 1'b0, DM_w,  4*DEPTH, '0);
    issue(0, 1'b1, DM_w,  4*DEPTH, 32'hCAFE_F00D);
    issue(0, 1'b0, 3'd3,  32'h10, '0);
    issue(0, 1'b0, DM_w,  32'h10, '0);
    issue(0, 1'b0, DM_w,  32'h00, '0);
    issue(0, 1'b1, DM_h,  32'h1E, 32'h0000_8001);
    issue(0, 1'b0, DM_h,  32'h1E, '0);
    issue(0, 1'b0, DM_hu, 32'h1E, '0);
    rand_ops(0, 150);

    issue(0, 1'b1, DM_w, 32'h20, 32'hDEAD_BEEF);
    @(negedge clk);
    do_reset(0, 32'h20);
    issue(0, 1'b0, DM_w, 32'h20, '0);

    do_reset(1, 32'h3C);
    issue(1, 1'b1, DM_w, 32'h3C, 32'hA5A5_5A5A);
    issue(1, 1'b0, DM_w, 32'h3C, '0);
    issue(1, 1'b0, DM_h, 32'h3E, '0);
    rand_ops(1, 150);

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
